// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer: ping-pong reorder of bit-reversed FFT frames into natural order; FFT_BITREV_FRAME_CHECK_EN adds s_last/frame_err.
// Latency: first output one clk after a frame's last input. Backpressure: s_ready drops only with both banks full; m_data holds while m_ready=0.

package fft_pkg;
    localparam int DATA_WIDTH = 16;
endpackage

module fft_bitrev_buffer #(
    parameter int N_LOG2     = 4,
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef FFT_BITREV_FRAME_CHECK_EN
    input  logic                    s_last,
    output logic                    frame_err,
`endif
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [2*DATA_WIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [2*DATA_WIDTH-1:0] m_data,
    output logic                    m_last
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
    } complex_t;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] idx);
        logic [N_LOG2-1:0] res;
        for (int k = 0; k < N_LOG2; k++) begin
            res[k] = idx[N_LOG2-1-k];
        end
        return res;
    endfunction

    complex_t          r_bank0 [N];
    complex_t          r_bank1 [N];

    logic              r_wr_sel;
    logic [N_LOG2-1:0] r_wr_cnt;
    logic              r_rd_sel;
    logic [N_LOG2-1:0] r_rd_cnt;
    logic [1:0]        r_full;
    logic              r_m_valid;
    logic              r_m_last;
    complex_t          r_m_data;

    logic              w_wr_fire;
    logic              w_wr_wrap;
    logic              w_load;
    logic              w_rd_wrap;
    logic [N_LOG2-1:0] w_rd_addr;
    complex_t          w_rd_word;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;

    assign s_ready   = ~r_full[r_wr_sel];
    assign w_wr_fire = s_valid & s_ready;
    assign w_wr_wrap = (r_wr_cnt == LAST_IDX);

    // The output register is free when empty or being drained this cycle.
    assign w_load    = r_full[r_rd_sel] & (~r_m_valid | m_ready);
    assign w_rd_wrap = (r_rd_cnt == LAST_IDX);
    assign w_rd_addr = bitrev(r_rd_cnt);
    assign w_rd_word = r_rd_sel ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

    always_comb begin
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        if (w_wr_fire && w_wr_wrap) begin
            w_full_set[r_wr_sel] = 1'b1;
        end
        if (w_load && w_rd_wrap) begin
            w_full_clr[r_rd_sel] = 1'b1;
        end
    end

    // Sample storage carries no reset; stale contents are fenced off by r_full.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            if (r_wr_sel) begin
                r_bank1[r_wr_cnt] <= complex_t'(s_data);
            end else begin
                r_bank0[r_wr_cnt] <= complex_t'(s_data);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sel <= 1'b0;
            r_wr_cnt <= '0;
        end else if (w_wr_fire) begin
            r_wr_cnt <= r_wr_cnt + N_LOG2'(1);
            if (w_wr_wrap) begin
                r_wr_sel <= ~r_wr_sel;
            end
        end
    end

    // Set and clear always address different banks, so both apply together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_sel  <= 1'b0;
            r_rd_cnt  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (w_load) begin
            r_m_data  <= w_rd_word;
            r_m_valid <= 1'b1;
            r_m_last  <= w_rd_wrap;
            r_rd_cnt  <= r_rd_cnt + N_LOG2'(1);
            if (w_rd_wrap) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_data  = r_m_data;

`ifdef FFT_BITREV_FRAME_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (w_wr_fire && (s_last != w_wr_wrap)) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule
